// File: rtl/uart_loopback_pkg.sv
// Shared constants for the uart loopback echo engine: transform modes,
// transmit FSM encoding and ASCII letter bounds used by the case-swap mode.
package uart_loopback_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_CASE = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } tx_state_e;

    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    function automatic logic is_ascii_letter(input logic [7:0] b);
        return ((b >= ASCII_UPPER_LO) && (b <= ASCII_UPPER_HI)) ||
               ((b >= ASCII_LOWER_LO) && (b <= ASCII_LOWER_HI));
    endfunction

endpackage

// File: rtl/uart_loopback_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; an extra pointer bit separates full from empty.
// A write while full is accepted only when a read frees the slot the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_wr_s;
    logic                do_rd_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Qualify requests and advance pointers
    always_comb begin
        do_rd_s  = rd_en && !empty;
        do_wr_s  = wr_en && (!full || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// Echo engine: transforms each received word, buffers it and re-offers it to
// the transmitter under a valid/ack handshake, with traffic statistics.
module uart_loopback_fifo
    import uart_loopback_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int INC_VAL    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_data_fresh,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_data_ack,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [CNT_W-1:0]      rx_count,
    output logic [CNT_W-1:0]      tx_count,
    output logic [CNT_W-1:0]      drop_count,
    input  logic                  clr_stats
);

    localparam logic [DATA_W-1:0] INC_W   = DATA_W'(INC_VAL);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] case_swap_s;
    logic [DATA_W-1:0] xform_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              ack_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_rd_data_s;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;

    // Case swap only has meaning for byte-wide data; wider/narrower words pass
    generate
        if (DATA_W == 8) begin : g_case_swap
            // Flip the ASCII case bit of letters only
            always_comb begin
                if (is_ascii_letter(rx_data)) begin
                    case_swap_s = rx_data ^ ASCII_CASE_BIT;
                end else begin
                    case_swap_s = rx_data;
                end
            end
        end else begin : g_case_pass
            assign case_swap_s = rx_data;
        end
    endgenerate

    // Mode-selected transform applied on the write side
    always_comb begin
        xform_s = rx_data;
        case (mode)
            MODE_PASS: xform_s = rx_data;
            MODE_ADD:  xform_s = rx_data + INC_W;
            MODE_INV:  xform_s = ~rx_data;
            MODE_CASE: xform_s = case_swap_s;
            default:   xform_s = rx_data;
        endcase
    end

    assign push_s = rx_data_fresh && (!fifo_full_s || pop_s);
    assign drop_s = rx_data_fresh && !push_s;

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (xform_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    // Transmit FSM next state; the holding register is loaded on the pop
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop_s      = 1'b0;
        ack_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    tx_data_d  = fifo_rd_data_s;
                    tx_valid_d = 1'b1;
                    state_d    = ST_VALID;
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (tx_data_ack) begin
                    ack_s      = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_VALID;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Transmit FSM and its registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Statistics; a coincident clear beats any counted event
    always_comb begin
        rx_count_d   = rx_count_q;
        tx_count_d   = tx_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (clr_stats) begin
            rx_count_d   = '0;
            tx_count_d   = '0;
            drop_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (rx_data_fresh) begin
                rx_count_d = rx_count_q + CNT_ONE;
            end else begin
                rx_count_d = rx_count_q;
            end
            if (ack_s) begin
                tx_count_d = tx_count_q + CNT_ONE;
            end else begin
                tx_count_d = tx_count_q;
            end
            if (drop_s) begin
                overflow_d = 1'b1;
                if (drop_count_q != CNT_MAX) begin
                    drop_count_d = drop_count_q + CNT_ONE;
                end else begin
                    drop_count_d = drop_count_q;
                end
            end else begin
                overflow_d   = overflow_q;
                drop_count_d = drop_count_q;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_q   <= '0;
            tx_count_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            rx_count_q   <= rx_count_d;
            tx_count_q   <= tx_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign rx_count      = rx_count_q;
    assign tx_count      = tx_count_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo: transformed words are queued when
// sent and compared in order as the transmitter acknowledges them.
module tb_uart_loopback_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_fresh = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [15:0] drop_count;
    logic        clr_stats = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    uart_loopback_fifo #(
        .DATA_W(8), .DEPTH_LOG2(4), .INC_VAL(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data),
        .rx_data_fresh(rx_data_fresh), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack),
        .fifo_level(fifo_level), .overflow(overflow), .rx_count(rx_count),
        .tx_count(tx_count), .drop_count(drop_count), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_xform(input logic [1:0] m, input logic [7:0] d);
        case (m)
            2'd0: return d;
            2'd1: return d + 8'd1;
            2'd2: return ~d;
            default: begin
                if (d >= 8'h41 && d <= 8'h5A) return d + 8'h20;
                else if (d >= 8'h61 && d <= 8'h7A) return d - 8'h20;
                else return d;
            end
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d, input bit accept);
        mode = m;
        rx_data = d;
        rx_data_fresh = 1'b1;
        if (accept) exp_q.push_back(model_xform(m, d));
        cyc();
        rx_data_fresh = 1'b0;
    endtask

    task automatic ack_head(input string tag);
        logic [7:0] e;
        chk({tag, "_sb"}, {31'd0, exp_q.size() != 0}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk(tag, {24'd0, tx_data}, {24'd0, e});
        tx_data_ack = 1'b1;
        cyc();
        tx_data_ack = 1'b0;
        chk({tag, "_vlow"}, {31'd0, tx_data_valid}, 32'd0);
    endtask

    task automatic recv(input string tag);
        int n;
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, tx_data_valid}, 32'd1);
        ack_head(tag);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", {31'd0, tx_data_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rxc", {16'd0, rx_count}, 32'd0);
        chk("rst_txc", {16'd0, tx_count}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);

        // Mode 1 latency and handshake
        send(2'd1, 8'h41, 1'b1);
        chk("lat_1cyc", {31'd0, tx_data_valid}, 32'd0);
        cyc();
        chk("lat_2cyc", {31'd0, tx_data_valid}, 32'd1);
        recv("m1_data");
        chk("m1_rxc", {16'd0, rx_count}, 32'd1);
        chk("m1_txc", {16'd0, tx_count}, 32'd1);

        // Modes 0/2/3
        send(2'd0, 8'h61, 1'b1);
        send(2'd2, 8'h61, 1'b1);
        send(2'd3, 8'h61, 1'b1);
        send(2'd3, 8'h35, 1'b1);
        for (int i = 0; i < 4; i++) recv($sformatf("modes_%0d", i));
        chk("modes_txc", {16'd0, tx_count}, 32'd5);

        // Backpressure: 18 words, no ack
        for (int i = 0; i < 18; i++) send(2'd0, 8'h10 + 8'(i), i < 17);
        chk("bp_valid", {31'd0, tx_data_valid}, 32'd1);
        chk("bp_level", {27'd0, fifo_level}, 32'd16);
        chk("bp_ovf", {31'd0, overflow}, 32'd1);
        chk("bp_drop", {16'd0, drop_count}, 32'd1);
        chk("bp_rxc", {16'd0, rx_count}, 32'd23);
        for (int i = 0; i < 17; i++) recv($sformatf("bp_out_%0d", i));
        chk("bp_empty", {27'd0, fifo_level}, 32'd0);
        chk("bp_txc", {16'd0, tx_count}, 32'd22);

        // Full FIFO with push coincident with the ack-triggered pop
        for (int i = 0; i < 17; i++) send(2'd2, 8'h80 + 8'(i), 1'b1);
        chk("fp_level", {27'd0, fifo_level}, 32'd16);
        ack_head("fp_head");
        send(2'd1, 8'hFF, 1'b1);
        chk("fp_level2", {27'd0, fifo_level}, 32'd16);
        chk("fp_drop", {16'd0, drop_count}, 32'd1);
        for (int i = 0; i < 17; i++) recv($sformatf("fp_out_%0d", i));

        // Reset mid-transfer
        for (int i = 0; i < 6; i++) send(2'd0, 8'hC0 + 8'(i), 1'b1);
        chk("mr_valid", {31'd0, tx_data_valid}, 32'd1);
        chk("mr_level", {27'd0, fifo_level}, 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        chk("mr_valid0", {31'd0, tx_data_valid}, 32'd0);
        chk("mr_level0", {27'd0, fifo_level}, 32'd0);
        chk("mr_rxc", {16'd0, rx_count}, 32'd0);
        chk("mr_txc", {16'd0, tx_count}, 32'd0);
        chk("mr_drop", {16'd0, drop_count}, 32'd0);
        chk("mr_ovf", {31'd0, overflow}, 32'd0);
        tx_data_ack = 1'b1;
        cyc();
        tx_data_ack = 1'b0;
        chk("stray_txc", {16'd0, tx_count}, 32'd0);
        chk("stray_valid", {31'd0, tx_data_valid}, 32'd0);

        // clr_stats coincident with a received word
        for (int i = 0; i < 18; i++) send(2'd3, 8'h50 + 8'(i), i < 17);
        chk("cs_ovf_set", {31'd0, overflow}, 32'd1);
        ack_head("cs_head");
        clr_stats = 1'b1;
        send(2'd0, 8'hA5, 1'b1);
        clr_stats = 1'b0;
        chk("cs_rxc", {16'd0, rx_count}, 32'd0);
        chk("cs_txc", {16'd0, tx_count}, 32'd0);
        chk("cs_drop", {16'd0, drop_count}, 32'd0);
        chk("cs_ovf", {31'd0, overflow}, 32'd0);
        chk("cs_level", {27'd0, fifo_level}, 32'd16);
        for (int i = 0; i < 17; i++) recv($sformatf("cs_out_%0d", i));
        chk("cs_txc_end", {16'd0, tx_count}, 32'd17);
        chk("cs_sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
